// File: rtl/alu_mul_sequencer_if.sv
// Signal bundle between the execute stage, the shared ALU and the multiply sequencer.
// The master side is the pipeline/ALU. The slave side is the sequencer that borrows the ALU.
interface alu_mul_sequencer_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        ex_req;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [2:0]  ex_f;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (
        output start, op_a, op_b, ex_req, ex_a, ex_b, ex_f, alu_y,
        input  alu_a, alu_b, alu_f, busy, done, product
    );

    modport slave (
        input  start, op_a, op_b, ex_req, ex_a, ex_b, ex_f, alu_y,
        output alu_a, alu_b, alu_f, busy, done, product
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier (low 32 bits) that borrows the execute ALU for its add steps.
// One step per cycle up to the top set bit of op_b. Add steps stall while the pipeline holds the ALU.
module alu_mul_sequencer (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_mul_sequencer_if.slave   bus_if
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] ALU_ADD = 3'd2;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic        seq_use;
    logic        step_adv;

    // The pipeline always wins the ALU; only ALU-needing steps can lose it.
    assign seq_use  = (state_q == RUN) && mplier_q[0] && !bus_if.ex_req;
    assign step_adv = (state_q == RUN) && (!mplier_q[0] || seq_use);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus_if.start) begin
                    mcand_d  = bus_if.op_a;
                    mplier_d = bus_if.op_b;
                    acc_d    = '0;
                    state_d  = (bus_if.op_b == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (step_adv) begin
                    if (mplier_q[0]) begin
                        acc_d = bus_if.alu_y;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if ((mplier_q >> 1) == 32'd0) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_if.alu_a = bus_if.ex_a;
        bus_if.alu_b = bus_if.ex_b;
        bus_if.alu_f = bus_if.ex_f;
        if (seq_use) begin
            bus_if.alu_a = acc_q;
            bus_if.alu_b = mcand_q;
            bus_if.alu_f = ALU_ADD;
        end
    end

    assign bus_if.product = acc_q;
    assign bus_if.busy    = (state_q == RUN);
    assign bus_if.done    = (state_q == DONE);
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Randomized bench for alu_mul_sequencer with a bit-serial product model and a small ALU model.
// Checks the outputs every cycle, the stall accounting, ignored starts and reset mid-run.
module tb_alu_mul_sequencer;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execute-stage ALU: combinational, function 2 is add.
    always_comb begin
        case (bus.alu_f)
            3'd0:    bus.alu_y = bus.alu_a & bus.alu_b;
            3'd1:    bus.alu_y = bus.alu_a | bus.alu_b;
            3'd2:    bus.alu_y = bus.alu_a + bus.alu_b;
            3'd3:    bus.alu_y = bus.alu_a - bus.alu_b;
            default: bus.alu_y = bus.alu_a ^ bus.alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_ex_random();
        bus.ex_a = $urandom;
        bus.ex_b = $urandom;
        bus.ex_f = 3'($urandom_range(0, 7));
    endtask

    // mode 0: pipeline idle, 1: random ALU requests, 2: requests in the first two cycles only.
    // poke re-asserts start with (1,1) one cycle into the run; it must have no effect.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int mode, input bit poke);
        int          n;
        int          k;
        int          cyc;
        logic [31:0] part;
        logic [31:0] expect_prod;
        bit          use_alu;
        n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        expect_prod = a * b;

        @(negedge clk);
        bus.op_a   = a;
        bus.op_b   = b;
        bus.start  = 1'b1;
        bus.ex_req = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;

        k = 0;
        part = '0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            case (mode)
                1:       bus.ex_req = ($urandom_range(0, 2) == 0);
                2:       bus.ex_req = (cyc < 2);
                default: bus.ex_req = 1'b0;
            endcase
            drive_ex_random();
            bus.start = poke && (cyc == 1);
            if (poke && cyc == 1) begin
                bus.op_a = 32'd1;
                bus.op_b = 32'd1;
            end
            #1;
            chk("busy_run", {31'd0, bus.busy}, 32'd1);
            chk("done_run", {31'd0, bus.done}, 32'd0);
            chk("acc_partial", bus.product, part);
            use_alu = b[k] && !bus.ex_req;
            chk("alu_a", bus.alu_a, use_alu ? part : bus.ex_a);
            chk("alu_b", bus.alu_b, use_alu ? (a << k) : bus.ex_b);
            chk("alu_f", {29'd0, bus.alu_f}, use_alu ? 32'd2 : {29'd0, bus.ex_f});
            if (!b[k] || !bus.ex_req) begin
                if (b[k]) part = part + (a << k);
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start  = 1'b0;
        bus.ex_req = 1'b0;
        chk("steps_done", k, n);
        #1;
        chk("done_end", {31'd0, bus.done}, 32'd1);
        chk("busy_end", {31'd0, bus.busy}, 32'd0);
        chk("product", bus.product, expect_prod);
        // Result and flag hold in DONE; ALU belongs to the pipeline.
        bus.ex_req = 1'($urandom_range(0, 1));
        drive_ex_random();
        @(posedge clk);
        #2;
        chk("done_hold", {31'd0, bus.done}, 32'd1);
        chk("product_hold", bus.product, expect_prod);
        chk("alu_a_done", bus.alu_a, bus.ex_a);
        chk("alu_f_done", {29'd0, bus.alu_f}, {29'd0, bus.ex_f});
        bus.ex_req = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_product"}, bus.product, 32'd0);
        chk({tag, "_alu_a"}, bus.alu_a, bus.ex_a);
        chk({tag, "_alu_b"}, bus.alu_b, bus.ex_b);
        chk({tag, "_alu_f"}, {29'd0, bus.alu_f}, {29'd0, bus.ex_f});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        total = 0;
        bad   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.ex_req = 1'b0;
        drive_ex_random();
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check_reset_state("idle");

        run_mul(32'd7, 32'd6, 0, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_mul(32'h8000_0000, 32'd2, 0, 1'b0);
        run_mul(32'h0000_1234, 32'd0, 0, 1'b0);
        run_mul(32'd5, 32'd3, 2, 1'b0);
        run_mul(32'd9, 32'h0000_00F0, 0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 255);
                2:       rb = $urandom | 32'h8000_0000;
                default: rb = $urandom;
            endcase
            run_mul(ra, rb, 1, 1'b0);
        end

        // Reset in the middle of a run: state and mux revert immediately.
        @(negedge clk);
        bus.op_a  = 32'd9;
        bus.op_b  = 32'h0000_00FF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", {31'd0, bus.busy}, 32'd1);
        chk("mid_acc", bus.product, 32'd63);
        bus.ex_req = 1'b0;
        bus.ex_f   = 3'd5;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check_reset_state("post_rst");

        run_mul(32'd3, 32'd11, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
